usrt_apb_regfile: RTL and testbench

//  APB slave register file for the USRT: STATUS, TX, RX and CTRL registers.

---
 rtl/usrt_apb_regfile.sv | 264 ++++++++++++++++++++++++++
 tb/tb_usrt_apb_regfile.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/usrt_apb_regfile.sv
// ----------------------------------------------------------------------------
// usrt_apb_regfile
//
// APB slave register file for the USRT. It holds the STATUS, TX, RX and CTRL
// registers. TX and RX FIFOs sit between the APB master and the USRT
// serializer/deserializer. Wait states, PSLVERR reporting and a registered
// level interrupt are included.
//
// Register map (i_Paddr[31:30]):
//   00 STATUS (RO)  [0] tx_full [1] tx_empty [2] rx_full [3] rx_empty
//                   [4] rx_overrun
//   01 TX     (WO)  a write pushes i_Pwdata into the TX FIFO
//   10 RX     (RO)  a read pops the RX FIFO and returns the head entry
//   11 CTRL   (RW)  [0] tx_en [1] rx_en [2] irq_rx_ne_en [3] irq_tx_empty_en
//                   [4] write-1-to-clear rx_overrun (always reads 0)
//
// Ports:
//   i_Pclk, i_Presetn             clock, asynchronous active-low reset
//   i_Psel, i_Penable, i_Pwrite,  APB request
//   i_Paddr, i_Pwdata
//   o_Prdata, o_Pready, o_Pslverr APB response
//   o_Tx_Data, o_Tx_Valid,        TX FIFO head towards the serializer
//   i_Tx_Ready
//   i_Rx_Data, i_Rx_Valid         deserialized words into the RX FIFO
//   o_Irq                         registered level interrupt
// ----------------------------------------------------------------------------
module usrt_apb_regfile #(
  parameter int DATA_W      = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int WAIT_STATES = 0
) (
  input  logic              i_Pclk,
  input  logic              i_Presetn,
  input  logic              i_Psel,
  input  logic              i_Penable,
  input  logic              i_Pwrite,
  input  logic [31:0]       i_Paddr,
  input  logic [DATA_W-1:0] i_Pwdata,
  output logic [DATA_W-1:0] o_Prdata,
  output logic              o_Pready,
  output logic              o_Pslverr,
  output logic [DATA_W-1:0] o_Tx_Data,
  output logic              o_Tx_Valid,
  input  logic              i_Tx_Ready,
  input  logic [DATA_W-1:0] i_Rx_Data,
  input  logic              i_Rx_Valid,
  output logic              o_Irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [3:0] WS_CNT = 4'(WAIT_STATES);

  localparam logic [1:0] REG_STATUS = 2'b00;
  localparam logic [1:0] REG_TX     = 2'b01;
  localparam logic [1:0] REG_RX     = 2'b10;
  localparam logic [1:0] REG_CTRL   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_DONE   = 2'b10
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [3:0]      ctrl_q, ctrl_d;
  logic            ovr_q, ovr_d;
  logic            irq_q, irq_d;
  logic [PW-1:0]   tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [PW-1:0]   rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];

  // Only the two register-select bits of the address are decoded.
  logic unused_paddr;
  assign unused_paddr = ^i_Paddr[29:0];

  // --------------------------------------------------------------------------
  // FIFO flags (extra pointer MSB distinguishes full from empty)
  // --------------------------------------------------------------------------
  logic tx_empty, tx_full, rx_empty, rx_full;

  assign tx_empty = (tx_wr_q == tx_rd_q);
  assign tx_full  = (tx_wr_q[AW] != tx_rd_q[AW]) &&
                    (tx_wr_q[AW-1:0] == tx_rd_q[AW-1:0]);
  assign rx_empty = (rx_wr_q == rx_rd_q);
  assign rx_full  = (rx_wr_q[AW] != rx_rd_q[AW]) &&
                    (rx_wr_q[AW-1:0] == rx_rd_q[AW-1:0]);

  logic [DATA_W-1:0] tx_head, rx_head;
  assign tx_head = tx_mem[tx_rd_q[AW-1:0]];
  assign rx_head = rx_mem[rx_rd_q[AW-1:0]];

  // --------------------------------------------------------------------------
  // APB FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge i_Pclk or negedge i_Presetn) begin
    if (!i_Presetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (i_Psel && i_Penable) begin
          state_d = ST_ACCESS;
          cnt_d   = 4'd0;
        end
      end
      ST_ACCESS: begin
        if (!i_Psel) begin
          // Master abandoned the transfer: nothing commits.
          state_d = ST_IDLE;
        end else if (cnt_q == WS_CNT) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_DONE: begin
        if (!i_Penable) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Ready is a pure decode of registered state so it never glitches on inputs.
  assign o_Pready = (state_q == ST_ACCESS) && (cnt_q == WS_CNT);

  logic       commit;
  logic [1:0] reg_sel;
  logic       wr_commit, rd_commit;

  assign commit    = o_Pready && i_Psel;
  assign reg_sel   = i_Paddr[31:30];
  assign wr_commit = commit && i_Pwrite;
  assign rd_commit = commit && !i_Pwrite;

  // --------------------------------------------------------------------------
  // FIFO push/pop decisions
  // --------------------------------------------------------------------------
  logic tx_pop, tx_push, rx_pop, rx_push_req, rx_push, ovr_set, ovr_clr, ctrl_wr;

  assign o_Tx_Valid  = !tx_empty && ctrl_q[0];
  assign tx_pop      = o_Tx_Valid && i_Tx_Ready;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign tx_push     = wr_commit && (reg_sel == REG_TX) && (!tx_full || tx_pop);

  assign rx_pop      = rd_commit && (reg_sel == REG_RX) && !rx_empty;
  assign rx_push_req = ctrl_q[1] && i_Rx_Valid;
  assign rx_push     = rx_push_req && (!rx_full || rx_pop);
  assign ovr_set     = rx_push_req && rx_full && !rx_pop;

  assign ctrl_wr     = wr_commit && (reg_sel == REG_CTRL);
  assign ovr_clr     = ctrl_wr && i_Pwdata[4];

  // Head is forced to 0 when empty so stale RAM contents never reach the pins.
  assign o_Tx_Data = tx_empty ? '0 : tx_head;

  // --------------------------------------------------------------------------
  // Next-state for control, overrun, pointers and interrupt
  // --------------------------------------------------------------------------
  always_comb begin
    ctrl_d  = ctrl_q;
    ovr_d   = ovr_q;
    tx_wr_d = tx_wr_q;
    tx_rd_d = tx_rd_q;
    rx_wr_d = rx_wr_q;
    rx_rd_d = rx_rd_q;

    if (ctrl_wr) begin
      ctrl_d = i_Pwdata[3:0];
    end

    // Set takes priority over a simultaneous write-1-to-clear.
    if (ovr_set) begin
      ovr_d = 1'b1;
    end else if (ovr_clr) begin
      ovr_d = 1'b0;
    end

    if (tx_push) tx_wr_d = tx_wr_q + PW'(1);
    if (tx_pop)  tx_rd_d = tx_rd_q + PW'(1);
    if (rx_push) rx_wr_d = rx_wr_q + PW'(1);
    if (rx_pop)  rx_rd_d = rx_rd_q + PW'(1);
  end

  assign irq_d = (ctrl_q[2] && !rx_empty) || (ctrl_q[3] && tx_empty) || ovr_q;

  always_ff @(posedge i_Pclk or negedge i_Presetn) begin
    if (!i_Presetn) begin
      ctrl_q  <= 4'd0;
      ovr_q   <= 1'b0;
      irq_q   <= 1'b0;
      tx_wr_q <= '0;
      tx_rd_q <= '0;
      rx_wr_q <= '0;
      rx_rd_q <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      ovr_q   <= ovr_d;
      irq_q   <= irq_d;
      tx_wr_q <= tx_wr_d;
      tx_rd_q <= tx_rd_d;
      rx_wr_q <= rx_wr_d;
      rx_rd_q <= rx_rd_d;
    end
  end

  assign o_Irq = irq_q;

  // FIFO storage is not reset; validity is tracked by the pointers alone.
  always_ff @(posedge i_Pclk) begin
    if (tx_push) tx_mem[tx_wr_q[AW-1:0]] <= i_Pwdata;
    if (rx_push) rx_mem[rx_wr_q[AW-1:0]] <= i_Rx_Data;
  end

  // --------------------------------------------------------------------------
  // Read data and error response (only while o_Pready is high)
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] status_word, ctrl_word;

  assign status_word = {{(DATA_W-5){1'b0}}, ovr_q, rx_empty, rx_full, tx_empty, tx_full};
  assign ctrl_word   = {{(DATA_W-4){1'b0}}, ctrl_q};

  always_comb begin
    o_Prdata  = '0;
    o_Pslverr = 1'b0;
    if (o_Pready) begin
      case (reg_sel)
        REG_STATUS: begin
          if (i_Pwrite) o_Pslverr = 1'b1;
          else          o_Prdata  = status_word;
        end
        REG_TX: begin
          if (i_Pwrite) o_Pslverr = tx_full && !tx_pop;
          else          o_Pslverr = 1'b1;
        end
        REG_RX: begin
          if (i_Pwrite)      o_Pslverr = 1'b1;
          else if (rx_empty) o_Pslverr = 1'b1;
          else               o_Prdata  = rx_head;
        end
        default: begin
          if (!i_Pwrite) o_Prdata = ctrl_word;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usrt_apb_regfile.sv
module tb_usrt_apb_regfile;

  localparam logic [1:0] R_STATUS = 2'b00;
  localparam logic [1:0] R_TX     = 2'b01;
  localparam logic [1:0] R_RX     = 2'b10;
  localparam logic [1:0] R_CTRL   = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  psel_v, penable_v;
  logic        pwrite;
  logic [31:0] paddr;
  logic [7:0]  pwdata;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;

  logic [7:0] prdata0, txdata0, prdata1, txdata1;
  logic       pready0, pslverr0, txvalid0, irq0;
  logic       pready1, pslverr1, txvalid1, irq1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  usrt_apb_regfile #(.DATA_W(8), .FIFO_DEPTH(4), .WAIT_STATES(0)) dut0 (
    .i_Pclk(clk), .i_Presetn(rst_n), .i_Psel(psel_v[0]), .i_Penable(penable_v[0]),
    .i_Pwrite(pwrite), .i_Paddr(paddr), .i_Pwdata(pwdata),
    .o_Prdata(prdata0), .o_Pready(pready0), .o_Pslverr(pslverr0),
    .o_Tx_Data(txdata0), .o_Tx_Valid(txvalid0), .i_Tx_Ready(tx_ready),
    .i_Rx_Data(rx_data), .i_Rx_Valid(rx_valid), .o_Irq(irq0)
  );

  usrt_apb_regfile #(.DATA_W(8), .FIFO_DEPTH(4), .WAIT_STATES(3)) dut1 (
    .i_Pclk(clk), .i_Presetn(rst_n), .i_Psel(psel_v[1]), .i_Penable(penable_v[1]),
    .i_Pwrite(pwrite), .i_Paddr(paddr), .i_Pwdata(pwdata),
    .o_Prdata(prdata1), .o_Pready(pready1), .o_Pslverr(pslverr1),
    .o_Tx_Data(txdata1), .o_Tx_Valid(txvalid1), .i_Tx_Ready(tx_ready),
    .i_Rx_Data(rx_data), .i_Rx_Valid(rx_valid), .o_Irq(irq1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One APB transfer on the selected DUT; returns data, error and the number
  // of clock edges from the first PENABLE cycle until PREADY was seen.
  task automatic apb(input int which, input logic wr, input logic [1:0] rsel,
                     input logic [7:0] wd, output logic [7:0] rd,
                     output logic err, output int cyc);
    logic got;
    @(negedge clk);
    paddr  = {rsel, 30'h0};
    pwrite = wr;
    pwdata = wd;
    psel_v[which]    = 1'b1;
    penable_v[which] = 1'b0;
    @(negedge clk);
    penable_v[which] = 1'b1;
    cyc = 0; rd = '0; err = 1'b0; got = 1'b0;
    while (!got && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if ((which == 0) ? pready0 : pready1) begin
        got = 1'b1;
        rd  = (which == 0) ? prdata0 : prdata1;
        err = (which == 0) ? pslverr0 : pslverr1;
      end
    end
    chk("apb_ready_seen", 32'(got), 32'd1);
    @(posedge clk); #1;
    psel_v[which]    = 1'b0;
    penable_v[which] = 1'b0;
    $display("apb dut%0d %s reg=%0d wdata=0x%02h rdata=0x%02h err=%0d cycles=%0d",
             which, wr ? "WR" : "RD", rsel, wd, rd, err, cyc);
  endtask

  initial begin
    logic [7:0] rd;
    logic       err;
    int         cyc;

    rst_n = 1'b0; psel_v = '0; penable_v = '0; pwrite = 1'b0; paddr = '0;
    pwdata = '0; tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;

    // 1. Reset state and STATUS read
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pready", 32'(pready0), 0);
    chk("rst_prdata", 32'(prdata0), 0);
    chk("rst_pslverr", 32'(pslverr0), 0);
    chk("rst_txvalid", 32'(txvalid0), 0);
    chk("rst_txdata", 32'(txdata0), 0);
    chk("rst_irq", 32'(irq0), 0);
    @(negedge clk); rst_n = 1'b1;
    apb(0, 1'b0, R_STATUS, 8'h00, rd, err, cyc);
    chk("status_rst", 32'(rd), 32'h0A);
    chk("status_rst_err", 32'(err), 0);
    chk("ws0_latency", 32'(cyc), 1);

    // 2. TX path with tx_en
    apb(0, 1'b1, R_CTRL, 8'h01, rd, err, cyc);
    chk("ctrl_wr_err", 32'(err), 0);
    apb(0, 1'b1, R_TX, 8'hCA, rd, err, cyc);
    apb(0, 1'b1, R_TX, 8'hB3, rd, err, cyc);
    chk("tx_wr_err", 32'(err), 0);
    @(negedge clk);
    chk("tx_valid_held", 32'(txvalid0), 1);
    chk("tx_head_ca", 32'(txdata0), 32'hCA);
    tx_ready = 1'b1;
    @(posedge clk); #1;
    chk("tx_head_b3", 32'(txdata0), 32'hB3);
    @(posedge clk); #1;
    chk("tx_drained_valid", 32'(txvalid0), 0);
    chk("tx_drained_data", 32'(txdata0), 0);
    @(negedge clk); tx_ready = 1'b0;
    apb(0, 1'b0, R_STATUS, 8'h00, rd, err, cyc);
    chk("status_tx_empty", 32'(rd), 32'h0A);
    apb(0, 1'b0, R_CTRL, 8'h00, rd, err, cyc);
    chk("ctrl_readback", 32'(rd), 32'h01);

    // 3. TX overflow with tx_en=0
    apb(0, 1'b1, R_CTRL, 8'h00, rd, err, cyc);
    for (int i = 1; i <= 5; i++) begin
      apb(0, 1'b1, R_TX, 8'(i), rd, err, cyc);
      chk("tx_fill_err", 32'(err), (i == 5) ? 32'd1 : 32'd0);
    end
    apb(0, 1'b0, R_STATUS, 8'h00, rd, err, cyc);
    chk("status_tx_full", 32'(rd), 32'h09);
    apb(0, 1'b1, R_CTRL, 8'h01, rd, err, cyc);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("tx_drain_order", 32'(txdata0), 32'(i));
      tx_ready = 1'b1;
    end
    @(negedge clk);
    chk("tx_drop_5th", 32'(txvalid0), 0);
    tx_ready = 1'b0;
    apb(0, 1'b1, R_CTRL, 8'h00, rd, err, cyc);

    // Illegal accesses
    apb(0, 1'b1, R_STATUS, 8'hFF, rd, err, cyc);
    chk("wr_status_err", 32'(err), 1);
    apb(0, 1'b0, R_TX, 8'h00, rd, err, cyc);
    chk("rd_tx_data", 32'(rd), 0);
    chk("rd_tx_err", 32'(err), 1);
    apb(0, 1'b1, R_RX, 8'h55, rd, err, cyc);
    chk("wr_rx_err", 32'(err), 1);
    apb(0, 1'b0, R_STATUS, 8'h00, rd, err, cyc);
    chk("status_unchanged", 32'(rd), 32'h0A);

    // 4. RX overrun and interrupt
    apb(0, 1'b1, R_CTRL, 8'h02, rd, err, cyc);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = 8'(i * 17);
    end
    @(negedge clk);
    rx_valid = 1'b0;
    chk("irq_one_cycle_lag", 32'(irq0), 0);
    @(posedge clk); #1;
    chk("irq_overrun", 32'(irq0), 1);
    apb(0, 1'b0, R_STATUS, 8'h00, rd, err, cyc);
    chk("status_overrun", 32'(rd), 32'h16);
    for (int i = 1; i <= 4; i++) begin
      apb(0, 1'b0, R_RX, 8'h00, rd, err, cyc);
      chk("rx_data_order", 32'(rd), 32'(i * 17));
      chk("rx_rd_err", 32'(err), 0);
    end
    apb(0, 1'b0, R_RX, 8'h00, rd, err, cyc);
    chk("rx_empty_data", 32'(rd), 0);
    chk("rx_empty_err", 32'(err), 1);
    chk("irq_sticky", 32'(irq0), 1);
    apb(0, 1'b1, R_CTRL, 8'h12, rd, err, cyc);
    @(posedge clk); #1;
    chk("irq_cleared", 32'(irq0), 0);
    apb(0, 1'b0, R_STATUS, 8'h00, rd, err, cyc);
    chk("status_ovr_clr", 32'(rd), 32'h0A);
    apb(0, 1'b0, R_CTRL, 8'h00, rd, err, cyc);
    chk("ctrl_w1c_reads0", 32'(rd), 32'h02);

    // Interrupt sources
    apb(0, 1'b1, R_CTRL, 8'h06, rd, err, cyc);
    @(posedge clk); #1;
    chk("irq_rxne_idle", 32'(irq0), 0);
    @(negedge clk); rx_valid = 1'b1; rx_data = 8'h66;
    @(negedge clk); rx_valid = 1'b0;
    @(posedge clk); #1;
    chk("irq_rxne", 32'(irq0), 1);
    apb(0, 1'b0, R_RX, 8'h00, rd, err, cyc);
    chk("rx_single", 32'(rd), 32'h66);
    @(posedge clk); #1;
    chk("irq_rxne_clr", 32'(irq0), 0);
    apb(0, 1'b1, R_CTRL, 8'h08, rd, err, cyc);
    @(posedge clk); #1;
    chk("irq_txempty", 32'(irq0), 1);
    apb(0, 1'b1, R_CTRL, 8'h00, rd, err, cyc);

    // 5. Wait states and aborted transfer on the WAIT_STATES=3 instance
    apb(1, 1'b1, R_TX, 8'h5A, rd, err, cyc);
    chk("ws3_latency", 32'(cyc), 4);
    chk("ws3_err", 32'(err), 0);
    apb(1, 1'b1, R_TX, 8'h5B, rd, err, cyc);
    apb(1, 1'b1, R_TX, 8'h5C, rd, err, cyc);
    apb(1, 1'b0, R_STATUS, 8'h00, rd, err, cyc);
    chk("ws3_status3", 32'(rd), 32'h08);
    @(negedge clk);
    paddr = {R_TX, 30'h0}; pwrite = 1'b1; pwdata = 8'h77;
    psel_v[1] = 1'b1; penable_v[1] = 1'b0;
    @(negedge clk); penable_v[1] = 1'b1;
    @(posedge clk); #1;
    chk("abort_wait0", 32'(pready1), 0);
    @(posedge clk); #1;
    chk("abort_wait1", 32'(pready1), 0);
    @(negedge clk); psel_v[1] = 1'b0; penable_v[1] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("abort_no_ready", 32'(pready1), 0);
    apb(1, 1'b0, R_STATUS, 8'h00, rd, err, cyc);
    chk("abort_no_push", 32'(rd), 32'h08);
    apb(1, 1'b1, R_TX, 8'h5D, rd, err, cyc);
    apb(1, 1'b0, R_STATUS, 8'h00, rd, err, cyc);
    chk("ws3_full", 32'(rd), 32'h09);

    // 6. Reset during a committing TX write
    apb(0, 1'b1, R_CTRL, 8'h07, rd, err, cyc);
    @(negedge clk); rx_valid = 1'b1; rx_data = 8'h3C;
    @(negedge clk); rx_valid = 1'b0;
    apb(0, 1'b1, R_TX, 8'h42, rd, err, cyc);
    @(negedge clk);
    chk("pre_rst_irq", 32'(irq0), 1);
    chk("pre_rst_txvalid", 32'(txvalid0), 1);
    chk("pre_rst_txdata", 32'(txdata0), 32'h42);
    paddr = {R_TX, 30'h0}; pwrite = 1'b1; pwdata = 8'h99;
    psel_v[0] = 1'b1; penable_v[0] = 1'b0;
    @(negedge clk); penable_v[0] = 1'b1;
    @(posedge clk); #1;
    chk("pre_rst_pready", 32'(pready0), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pready", 32'(pready0), 0);
    chk("arst_prdata", 32'(prdata0), 0);
    chk("arst_pslverr", 32'(pslverr0), 0);
    chk("arst_txvalid", 32'(txvalid0), 0);
    chk("arst_txdata", 32'(txdata0), 0);
    chk("arst_irq", 32'(irq0), 0);
    @(negedge clk); psel_v[0] = 1'b0; penable_v[0] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    apb(0, 1'b0, R_STATUS, 8'h00, rd, err, cyc);
    chk("post_rst_status", 32'(rd), 32'h0A);
    apb(0, 1'b0, R_CTRL, 8'h00, rd, err, cyc);
    chk("post_rst_ctrl", 32'(rd), 32'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
